// File: rtl/booth_mult_pkg.sv
// booth_mult_pkg -- shared definitions for the Booth multiplier.
//   state_t      : controller states (IDLE, RUN, DONE)
//   ZERO..MINUS2 : Booth digit codes produced by booth_recoder
//   DIGIT_BITS   : width of the multiplier window fed to the recoder
//   SHIFT        : multiplier bits retired per iteration
//   iterations() : number of iterations for a given extended operand width
// Build option: define BOOTH_MULT_RADIX4_EN for radix-4 recoding
// (3-bit window, 2-bit shift); otherwise radix-2 (2-bit window, 1-bit shift).
package booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] ZERO   = 3'd0;
    localparam logic [2:0] PLUS1  = 3'd1;
    localparam logic [2:0] MINUS1 = 3'd2;
    localparam logic [2:0] PLUS2  = 3'd3;
    localparam logic [2:0] MINUS2 = 3'd4;

`ifdef BOOTH_MULT_RADIX4_EN
    localparam int DIGIT_BITS = 3;
    localparam int SHIFT      = 2;
`else
    localparam int DIGIT_BITS = 2;
    localparam int SHIFT      = 1;
`endif

    function automatic int iterations(input int ext_width);
        return ext_width / SHIFT;
    endfunction

endpackage

// File: rtl/booth_mult_recoder.sv
// booth_recoder -- combinational Booth digit selection.
//   bits  (in)  : multiplier window {b_lsb(s), aux}; 2 bits radix-2, 3 bits radix-4
//   digit (out) : one of ZERO, PLUS1, MINUS1, PLUS2, MINUS2
// Build option: BOOTH_MULT_RADIX4_EN selects the radix-4 triplet table.
module booth_recoder
    import booth_mult_pkg::*;
(
    input  logic [DIGIT_BITS-1:0] bits,
    output logic [2:0]            digit
);

    always_comb begin
        digit = ZERO;
`ifdef BOOTH_MULT_RADIX4_EN
        case (bits)
            3'b001, 3'b010: digit = PLUS1;
            3'b011:         digit = PLUS2;
            3'b100:         digit = MINUS2;
            3'b101, 3'b110: digit = MINUS1;
            default:        digit = ZERO;
        endcase
`else
        case (bits)
            2'b01:   digit = PLUS1;
            2'b10:   digit = MINUS1;
            default: digit = ZERO;
        endcase
`endif
    end

endmodule

// File: rtl/booth_mult.sv
// booth_mult -- sequential Booth multiplier, signed or unsigned operands.
// All state changes on the falling edge of clk; reset is asynchronous, active-low.
//   clk       (in)  : clock
//   reset     (in)  : asynchronous active-low reset
//   a, b      (in)  : multiplicand / multiplier, sampled when start is accepted
//   is_signed (in)  : 1 = two's-complement operands, 0 = unsigned
//   start     (in)  : request, accepted in IDLE or DONE only
//   busy      (out) : high while iterating
//   done      (out) : one-cycle pulse, z valid
//   z         (out) : 2*WIDTH-bit product, held until the next result or reset
// Build option: BOOTH_MULT_RADIX4_EN selects radix-4 (E/2 iterations)
// instead of radix-2 (E iterations); results are identical.
module booth_mult
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] z
);

    // Two guard bits make unsigned operands positive signed values, so one
    // signed Booth engine serves both modes.
    localparam int E  = WIDTH + 2;
    localparam int N  = iterations(E);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N);

    state_t              state_reg, state_next;
    logic [CW-1:0]       count_reg;
    logic [E:0]          acc_reg;
    logic [E-1:0]        mcand_reg;
    logic [E-1:0]        mult_reg;
    logic                aux_reg;
    logic [2*WIDTH-1:0]  z_reg;

    logic                accept;
    logic                last_iter;
    logic [DIGIT_BITS-1:0] window;
    logic [2:0]          digit;
    logic [E:0]          m1, m2, addend, sum;
    logic [E:0]          acc_next;
    logic [E-1:0]        mult_next;
    logic                aux_next;

    assign accept    = start && (state_reg != RUN);
    assign last_iter = (count_reg == LAST);

    // Window is the low multiplier bit(s) plus the bit shifted out last time.
    assign window = {mult_reg[DIGIT_BITS-2:0], aux_reg};

    booth_recoder u_recoder (
        .bits  (window),
        .digit (digit)
    );

    assign m1 = {mcand_reg[E-1], mcand_reg};
    assign m2 = {mcand_reg, 1'b0};

    always_comb begin
        addend = '0;
        case (digit)
            PLUS1:   addend = m1;
            MINUS1:  addend = -m1;
            PLUS2:   addend = m2;
            MINUS2:  addend = -m2;
            default: addend = '0;
        endcase
    end

    assign sum = acc_reg + addend;

    // Arithmetic right shift of {sum, mult, aux} by SHIFT bits.
    assign acc_next  = {{SHIFT{sum[E]}}, sum[E:SHIFT]};
    assign mult_next = {sum[SHIFT-1:0], mult_reg[E-1:SHIFT]};
    assign aux_next  = mult_reg[SHIFT-1];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            acc_reg   <= '0;
            mcand_reg <= '0;
            mult_reg  <= '0;
            aux_reg   <= 1'b0;
            z_reg     <= '0;
        end else begin
            if (accept) begin
                mcand_reg <= {{2{is_signed & a[WIDTH-1]}}, a};
                mult_reg  <= {{2{is_signed & b[WIDTH-1]}}, b};
                acc_reg   <= '0;
                aux_reg   <= 1'b0;
                count_reg <= '0;
            end else if (state_reg == RUN && !last_iter) begin
                acc_reg   <= acc_next;
                mult_reg  <= mult_next;
                aux_reg   <= aux_next;
                count_reg <= count_reg + CW'(1);
            end
            // Product sits in {acc, mult}; only published once complete.
            if (state_reg == RUN && last_iter) begin
                z_reg <= {acc_reg[WIDTH-3:0], mult_reg};
            end
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign z    = z_reg;

endmodule

// File: tb/tb_booth_mult.sv
module tb_booth_mult;

    localparam int W  = 32;
    localparam int E  = W + 2;
`ifdef BOOTH_MULT_RADIX4_EN
    localparam int N  = E / 2;
    localparam int N8 = 5;
`else
    localparam int N  = E;
    localparam int N8 = 10;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [W-1:0]   a = '0, b = '0;
    logic           is_signed = 1'b0, start = 1'b0;
    logic           busy, done;
    logic [2*W-1:0] z;

    logic [7:0]     a8 = '0, b8 = '0;
    logic           s8 = 1'b0, start8 = 1'b0;
    logic           busy8, done8;
    logic [15:0]    z8;

    booth_mult #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .is_signed(is_signed),
        .start(start), .busy(busy), .done(done), .z(z)
    );

    booth_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .a(a8), .b(b8), .is_signed(s8),
        .start(start8), .busy(busy8), .done(done8), .z(z8)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] z;
    } vec_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] z;
    } vec8_t;

    vec_t  tbl[$];
    vec8_t tbl8[$];

    // Reference: exact integer product, truncated to 2*WIDTH bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint px, py;
        if (s) begin
            px = longint'($signed(x));
            py = longint'($signed(y));
        end else begin
            px = longint'({32'b0, x});
            py = longint'({32'b0, y});
        end
        return 64'(px * py);
    endfunction

    function automatic logic [15:0] ref_mul8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int px, py;
        if (s) begin
            px = int'($signed(x));
            py = int'($signed(y));
        end else begin
            px = int'({24'b0, x});
            py = int'({24'b0, y});
        end
        return 16'(px * py);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    // Called just after a rising edge; accepts on the next falling edge.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                         input logic [63:0] exp_z, input string nm);
        int cyc;
        a = ta; b = tb_v; is_signed = ts; start = 1'b1;
        tick();
        start = 1'b0; a = $urandom; b = $urandom; is_signed = ~ts;
        cyc = 0;
        while (done !== 1'b1 && cyc < N + 10) begin
            tick();
            cyc++;
            if (cyc == 1 || cyc == N) chk({nm, " busy"}, 64'(busy), 64'd1);
        end
        chk({nm, " latency"}, 64'(cyc), 64'(N + 1));
        chk({nm, " z"}, z, exp_z);
        chk({nm, " busy@done"}, 64'(busy), 64'd0);
        tick();
        chk({nm, " done pulse"}, 64'(done), 64'd0);
        chk({nm, " z hold"}, z, exp_z);
    endtask

    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                          input logic [15:0] exp_z, input string nm);
        int cyc;
        a8 = ta; b8 = tb_v; s8 = ts; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        cyc = 0;
        while (done8 !== 1'b1 && cyc < N8 + 10) begin
            tick();
            cyc++;
        end
        chk({nm, " latency"}, 64'(cyc), 64'(N8 + 1));
        chk({nm, " z"}, 64'(z8), 64'(exp_z));
        tick();
        chk({nm, " done pulse"}, 64'(done8), 64'd0);
    endtask

    initial begin
        int   pulses;
        int   cyc;
        vec_t v;
        vec8_t v8;

        tbl.push_back('{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, s: 1'b1, z: 64'h0000000000000001});
        tbl.push_back('{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, s: 1'b0, z: 64'hFFFFFFFE00000001});
        tbl.push_back('{a: 32'h80000000, b: 32'h80000000, s: 1'b1, z: 64'h4000000000000000});
        tbl.push_back('{a: 32'h80000000, b: 32'h00000001, s: 1'b1, z: 64'hFFFFFFFF80000000});
        tbl.push_back('{a: 32'h7FFFFFFF, b: 32'h80000000, s: 1'b1, z: 64'hC000000080000000});
        tbl.push_back('{a: 32'h80000000, b: 32'h80000000, s: 1'b0, z: 64'h4000000000000000});
        tbl.push_back('{a: 32'h00000000, b: 32'hDEADBEEF, s: 1'b1, z: 64'h0});
        tbl.push_back('{a: 32'h00000003, b: 32'h00000005, s: 1'b0, z: 64'd15});
        for (int i = 0; i < 20; i++) begin
            v.a = $urandom;
            v.b = $urandom;
            v.s = 1'($urandom_range(0, 1));
            v.z = ref_mul(v.a, v.b, v.s);
            tbl.push_back(v);
        end

        tbl8.push_back('{a: 8'h81, b: 8'h7F, s: 1'b1, z: 16'hC0FF});
        tbl8.push_back('{a: 8'h80, b: 8'h80, s: 1'b1, z: 16'h4000});
        tbl8.push_back('{a: 8'hFF, b: 8'hFF, s: 1'b0, z: 16'hFE01});
        tbl8.push_back('{a: 8'hFF, b: 8'hFF, s: 1'b1, z: 16'h0001});
        for (int i = 0; i < 10; i++) begin
            v8.a = 8'($urandom);
            v8.b = 8'($urandom);
            v8.s = 1'($urandom_range(0, 1));
            v8.z = ref_mul8(v8.a, v8.b, v8.s);
            tbl8.push_back(v8);
        end

        // Reset state
        repeat (3) @(posedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset z", z, 64'd0);
        chk("reset z8", 64'(z8), 64'd0);

        // First operation starts on the first falling edge after release
        reset = 1'b1;
        foreach (tbl[i]) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].z, $sformatf("vec%0d", i));
        end

        // Start during RUN ignored; start in DONE chains back-to-back
        a = 32'd3; b = 32'd5; is_signed = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int i = 1; i <= N + 1; i++) begin
            tick();
            if (i == 3) begin
                a = 32'd7; b = 32'd7; start = 1'b1;
            end else if (i == 4) begin
                start = 1'b0;
            end
            if (done === 1'b1) pulses++;
        end
        chk("ignore done@N+1", 64'(done), 64'd1);
        chk("ignore z", z, 64'd15);
        chk("ignore pulses", 64'(pulses), 64'd1);
        a = 32'd2; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < N + 10) begin
            tick();
            cyc++;
        end
        chk("chain latency", 64'(cyc), 64'(N + 1));
        chk("chain z", z, 64'd18);
        tick();

        // Reset in the middle of an operation
        a = 32'd6; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst z", z, 64'd0);
        @(posedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < N + 5; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        chk("midrst no done", 64'(pulses), 64'd0);
        do_op(32'd6, 32'd7, 1'b0, 64'd42, "after reset");

        // 8-bit instance
        foreach (tbl8[i]) begin
            do_op8(tbl8[i].a, tbl8[i].b, tbl8[i].s, tbl8[i].z, $sformatf("w8 vec%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
